// File: rtl/frac_search_pipe.sv
// rtl/frac_search_pipe.sv - fractional-pel candidate search: pipelined row SAD, per-candidate cost, running minimum
// Optional mv-cost weighting of each candidate is enabled by defining FRAC_SEARCH_MV_COST_EN.
module frac_search_pipe #(
    parameter int NPIX   = 8,
    parameter int PIX_W  = 8,
    parameter int ROWS   = 4,
    parameter int GRID   = 3,
    parameter int MV_W   = 3,
    parameter int SAD_W  = PIX_W + $clog2(NPIX * ROWS),
    parameter int LAMBDA = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NPIX*PIX_W-1:0] filter_pix,
    input  logic [NPIX*PIX_W-1:0] ref_pix,
    input  logic                  input_ready,
    output logic                  in_ready,
    output logic [MV_W-1:0]       mvx,
    output logic [MV_W-1:0]       mvy,
    output logic [SAD_W-1:0]      best_cost,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam int NCAND = GRID * GRID;
    localparam int CW    = (NCAND > 1) ? $clog2(NCAND) : 1;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int RSW   = PIX_W + ((NPIX > 1) ? $clog2(NPIX) : 0);

    localparam logic [CW-1:0]    LAST_CAND = CW'(NCAND - 1);
    localparam logic [RW-1:0]    LAST_ROW  = RW'(ROWS - 1);
    localparam logic [SAD_W-1:0] COST_MAX  = '1;

    typedef enum logic [1:0] {ACC, DRAIN, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic            drain_cnt;
    logic [RW-1:0]   row;
    logic [CW-1:0]   cand;
    logic            accept;
    logic            last_beat;
    logic            release_result;

    logic [RSW-1:0]  row_sum;
    logic            s1_valid;
    logic            s1_first;
    logic            s1_last;
    logic [CW-1:0]   s1_cand;
    logic [RSW-1:0]  s1_sad;

    logic            s2_valid;
    logic            s2_last;
    logic [CW-1:0]   s2_cand;
    logic [SAD_W-1:0] acc;

    logic [SAD_W-1:0] cand_cost;
    logic [SAD_W-1:0] best_r;
    logic [CW-1:0]    best_idx;
    logic             cost_ready;
    logic             take;
    logic [CW-1:0]    idx_next;
    logic [SAD_W-1:0] cost_next;

    assign in_ready       = (state == ACC);
    assign out_valid      = (state == DONE);
    assign accept         = input_ready & in_ready;
    assign last_beat      = (row == LAST_ROW) && (cand == LAST_CAND);
    assign release_result = (state == DONE) && out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ACC;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_next;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
        end
    end

    // DRAIN spans exactly the two edges the last beat needs to reach the compare stage
    always_comb begin
        state_next = state;
        case (state)
            ACC:     if (accept && last_beat) state_next = DRAIN;
            DRAIN:   if (drain_cnt) state_next = DONE;
            DONE:    if (out_ready) state_next = ACC;
            default: state_next = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            row  <= '0;
            cand <= '0;
        end else if (release_result) begin
            row  <= '0;
            cand <= '0;
        end else if (accept) begin
            if (row == LAST_ROW) begin
                row  <= '0;
                cand <= (cand == LAST_CAND) ? '0 : cand + 1'b1;
            end else begin
                row <= row + 1'b1;
            end
        end
    end

    function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    always_comb begin
        row_sum = '0;
        for (int i = 0; i < NPIX; i++) begin
            row_sum = row_sum + RSW'(abs_diff(filter_pix[i*PIX_W +: PIX_W],
                                              ref_pix[i*PIX_W +: PIX_W]));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_cand  <= '0;
            s1_sad   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_sad   <= row_sum;
                s1_first <= (row == '0);
                s1_last  <= (row == LAST_ROW);
                s1_cand  <= cand;
            end
        end
    end

    // Bubbles leave acc and the stage-2 tags untouched; only s2_valid gates their use
    always_ff @(posedge clk) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_cand  <= '0;
            acc      <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                acc     <= s1_first ? SAD_W'(s1_sad) : acc + SAD_W'(s1_sad);
                s2_last <= s1_last;
                s2_cand <= s1_cand;
            end
        end
    end

`ifdef FRAC_SEARCH_MV_COST_EN
    function automatic logic [SAD_W-1:0] mv_cost(input logic [SAD_W-1:0] sad,
                                                 input logic [CW-1:0]    c);
        int cx;
        int cy;
        int dx;
        int dy;
        logic [SAD_W+31:0] sum;
        cx  = int'(c) % GRID;
        cy  = int'(c) / GRID;
        dx  = (cx > GRID / 2) ? (cx - GRID / 2) : (GRID / 2 - cx);
        dy  = (cy > GRID / 2) ? (cy - GRID / 2) : (GRID / 2 - cy);
        sum = (SAD_W+32)'(sad) + (SAD_W+32)'(LAMBDA * (dx + dy));
        return (sum > (SAD_W+32)'(COST_MAX)) ? COST_MAX : sum[SAD_W-1:0];
    endfunction

    assign cand_cost = mv_cost(acc, s2_cand);
`else
    logic unused_lambda;
    assign unused_lambda = ^LAMBDA;
    assign cand_cost     = acc;
`endif

    // Strictly-less keeps the earlier (lower-index) candidate on ties
    assign cost_ready = s2_valid && s2_last;
    assign take       = cost_ready && (cand_cost < best_r);
    assign idx_next   = take ? s2_cand : best_idx;
    assign cost_next  = take ? cand_cost : best_r;

    always_ff @(posedge clk) begin
        if (!reset) begin
            best_r    <= COST_MAX;
            best_idx  <= '0;
            mvx       <= '0;
            mvy       <= '0;
            best_cost <= '0;
        end else if (release_result) begin
            best_r   <= COST_MAX;
            best_idx <= '0;
        end else begin
            if (take) begin
                best_r   <= cand_cost;
                best_idx <= s2_cand;
            end
            if (cost_ready && (s2_cand == LAST_CAND)) begin
                best_cost <= cost_next;
                mvx       <= MV_W'(int'(idx_next) % GRID);
                mvy       <= MV_W'(int'(idx_next) / GRID);
            end
        end
    end

endmodule

// File: tb/tb_frac_search_pipe.sv
// tb/tb_frac_search_pipe.sv - randomized self-checking bench for frac_search_pipe
module tb_frac_search_pipe;
    localparam int NPIX     = 8;
    localparam int PIX_W    = 8;
    localparam int ROWS     = 4;
    localparam int GRID     = 3;
    localparam int MV_W     = 3;
    localparam int SAD_W    = 13;
    localparam int LAMBDA   = 4;
    localparam int NCAND    = GRID * GRID;
    localparam int COST_MAX = (1 << SAD_W) - 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NPIX*PIX_W-1:0] filter_pix;
    logic [NPIX*PIX_W-1:0] ref_pix;
    logic                  input_ready;
    logic                  in_ready;
    logic [MV_W-1:0]       mvx;
    logic [MV_W-1:0]       mvy;
    logic [SAD_W-1:0]      best_cost;
    logic                  out_valid;
    logic                  out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    int fp[NCAND][ROWS][NPIX];
    int rp[NCAND][ROWS][NPIX];

    always #5 clk = ~clk;

    frac_search_pipe #(
        .NPIX(NPIX), .PIX_W(PIX_W), .ROWS(ROWS), .GRID(GRID),
        .MV_W(MV_W), .SAD_W(SAD_W), .LAMBDA(LAMBDA)
    ) dut (
        .clk(clk), .reset(reset), .filter_pix(filter_pix), .ref_pix(ref_pix),
        .input_ready(input_ready), .in_ready(in_ready), .mvx(mvx), .mvy(mvy),
        .best_cost(best_cost), .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: whole-block SAD per candidate, optional mv penalty, first strict minimum wins
    function automatic void model(output int ec, output int ex, output int ey);
        int best = COST_MAX;
        int bi   = 0;
        for (int c = 0; c < NCAND; c++) begin
            int s = 0;
            for (int r = 0; r < ROWS; r++)
                for (int i = 0; i < NPIX; i++)
                    s += (fp[c][r][i] > rp[c][r][i]) ? fp[c][r][i] - rp[c][r][i]
                                                     : rp[c][r][i] - fp[c][r][i];
`ifdef FRAC_SEARCH_MV_COST_EN
            begin
                int dx = c % GRID - GRID / 2;
                int dy = c / GRID - GRID / 2;
                if (dx < 0) dx = -dx;
                if (dy < 0) dy = -dy;
                s += LAMBDA * (dx + dy);
                if (s > COST_MAX) s = COST_MAX;
            end
`endif
            if (s < best) begin
                best = s;
                bi   = c;
            end
        end
        ec = best;
        ex = bi % GRID;
        ey = bi / GRID;
    endfunction

    task automatic fill_near(input int win, input bit shared, input int delta);
        for (int r = 0; r < ROWS; r++)
            for (int i = 0; i < NPIX; i++) begin
                int base = $urandom_range(254);
                for (int c = 0; c < NCAND; c++) begin
                    rp[c][r][i] = shared ? base : int'($urandom_range(254));
                    fp[c][r][i] = rp[c][r][i] + ((c == win) ? 0 : delta);
                end
            end
    endtask

    task automatic fill_random();
        for (int c = 0; c < NCAND; c++)
            for (int r = 0; r < ROWS; r++)
                for (int i = 0; i < NPIX; i++) begin
                    fp[c][r][i] = $urandom_range(255);
                    rp[c][r][i] = $urandom_range(255);
                end
    endtask

    task automatic fill_const(input int c, input int f, input int rv);
        for (int r = 0; r < ROWS; r++)
            for (int i = 0; i < NPIX; i++) begin
                fp[c][r][i] = f;
                rp[c][r][i] = rv;
            end
    endtask

    task automatic fill_sad(input int c, input int nd);
        for (int k = 0; k < ROWS * NPIX; k++) begin
            rp[c][k/NPIX][k%NPIX] = $urandom_range(254);
            fp[c][k/NPIX][k%NPIX] = rp[c][k/NPIX][k%NPIX] + ((k < nd) ? 1 : 0);
        end
    endtask

    task automatic put_beat(input int c, input int r, input int gap_pct);
        int g = 0;
        while (g < 3 && $urandom_range(99) < gap_pct) begin
            @(negedge clk);
            input_ready = 1'b0;
            filter_pix  = {$urandom, $urandom};
            ref_pix     = {$urandom, $urandom};
            g++;
        end
        @(negedge clk);
        for (int i = 0; i < NPIX; i++) begin
            filter_pix[i*PIX_W +: PIX_W] = PIX_W'(fp[c][r][i]);
            ref_pix[i*PIX_W +: PIX_W]    = PIX_W'(rp[c][r][i]);
        end
        input_ready = 1'b1;
        check("in_ready_acc", in_ready, 1);
        @(posedge clk);
    endtask

    task automatic run_block(input int gap_pct, input int hold);
        int ec;
        int ex;
        int ey;
        model(ec, ex, ey);
        for (int c = 0; c < NCAND; c++)
            for (int r = 0; r < ROWS; r++)
                put_beat(c, r, gap_pct);
        @(negedge clk);
        check("lat_e0_out_valid", out_valid, 0);
        check("drain_in_ready", in_ready, 0);
        @(negedge clk);
        check("lat_e1_out_valid", out_valid, 0);
        @(negedge clk);
        check("lat_e2_out_valid", out_valid, 1);
        check("mvx", mvx, ex);
        check("mvy", mvy, ey);
        check("best_cost", best_cost, ec);
        input_ready = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_in_ready", in_ready, 0);
            check("hold_out_valid", out_valid, 1);
            check("hold_mvx", mvx, ex);
            check("hold_mvy", mvy, ey);
            check("hold_best_cost", best_cost, ec);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        out_ready   = 1'b0;
        input_ready = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        input_ready = 1'b0;
        out_ready   = 1'b0;
        filter_pix  = '0;
        ref_pix     = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_mvx", mvx, 0);
        check("rst_mvy", mvy, 0);
        check("rst_best_cost", best_cost, 0);
        reset = 1'b1;

        fill_near(5, 1'b1, 1);
        run_block(0, 0);

        fill_near(0, 1'b1, 0);
        run_block(0, 1);

        for (int c = 0; c < NCAND - 1; c++) fill_const(c, 255, 0);
        fill_const(NCAND - 1, 1, 0);
        run_block(0, 2);

        fill_near(4, 1'b0, 1);
        run_block(0, 5);
        fill_near(7, 1'b0, 1);
        run_block(0, 0);

        for (int b = 0; b < 4; b++) begin
            fill_random();
            run_block(30, $urandom_range(3));
        end

        fill_random();
        for (int k = 0; k < 10; k++) put_beat(k / ROWS, k % ROWS, 0);
        @(negedge clk);
        input_ready = 1'b0;
        reset       = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_best_cost", best_cost, 0);
        fill_near(3, 1'b0, 1);
        run_block(20, 1);

        for (int c = 0; c < NCAND; c++) fill_const(c, 255, 0);
        fill_sad(0, 3);
        fill_sad(4, 10);
        run_block(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
